// File: rtl/square_draw_if.sv
// square_draw_if: command, renderer and plot-stream signals of the square draw sequencer.
interface square_draw_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SIZE_W = 5,
  parameter int COLOR_W = 3
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [X_W-1:0]     cmd_x;
  logic [Y_W-1:0]     cmd_y;
  logic [SIZE_W-1:0]  cmd_size;
  logic [COLOR_W-1:0] cmd_color;
  logic [X_W-1:0]     sq_origin_x;
  logic [Y_W-1:0]     sq_origin_y;
  logic [SIZE_W-1:0]  sq_size;
  logic               sq_enable;
  logic [X_W-1:0]     sq_x;
  logic [Y_W-1:0]     sq_y;
  logic               sq_finished;
  logic               plot;
  logic [X_W-1:0]     plot_x;
  logic [Y_W-1:0]     plot_y;
  logic [COLOR_W-1:0] plot_color;
  logic               cmd_dropped;
  logic               busy;
  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_size, cmd_color, sq_x, sq_y, sq_finished,
    output cmd_ready, sq_origin_x, sq_origin_y, sq_size, sq_enable,
           plot, plot_x, plot_y, plot_color, cmd_dropped, busy
  );
  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_size, cmd_color, sq_x, sq_y, sq_finished,
    input  cmd_ready, sq_origin_x, sq_origin_y, sq_size, sq_enable,
           plot, plot_x, plot_y, plot_color, cmd_dropped, busy
  );
endinterface

// File: rtl/square_draw_sequencer.sv
// square_draw_sequencer: queues square draw commands and sequences them through the renderer into a plot stream.
module square_draw_sequencer #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SIZE_W = 5,
  parameter int COLOR_W = 3,
  parameter int DEPTH = 4
) (
  input logic clock,
  input logic resetn,
  square_draw_if.master bus
);
  localparam int W = X_W + Y_W + SIZE_W + COLOR_W;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;
  state_t state_q, state_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [X_W-1:0] x_q, h_x;
  logic [Y_W-1:0] y_q, h_y;
  logic [SIZE_W-1:0] s_q, h_s;
  logic [COLOR_W-1:0] c_q, h_c;
  logic drop_q, drop_d, push, pop, empty;
  assign empty = cnt_q == '0;
  assign bus.cmd_ready = cnt_q != (AW+1)'(DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop = state_q == IDLE && !empty;
  assign {h_x, h_y, h_s, h_c} = mem_q[rd_q];
  always_comb begin
    state_d = state_q;
    drop_d = pop && h_s == '0;
    if (pop && !drop_d) state_d = LOAD;
    if (state_q == LOAD) state_d = DRAW;
    if (state_q == DRAW && bus.sq_finished) state_d = IDLE;
  end
  // Storage needs no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge clock)
    if (push) mem_q[wr_q] <= {bus.cmd_x, bus.cmd_y, bus.cmd_size, bus.cmd_color};
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      drop_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      s_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q <= rd_q + 1'b1;
        x_q <= h_x;
        y_q <= h_y;
        s_q <= h_s;
        c_q <= h_c;
      end
    end
  assign bus.sq_origin_x = x_q;
  assign bus.sq_origin_y = y_q;
  assign bus.sq_size = s_q;
  assign bus.sq_enable = state_q == DRAW;
  assign bus.plot = state_q == DRAW && !bus.sq_finished;
  assign bus.plot_x = bus.sq_x;
  assign bus.plot_y = bus.sq_y;
  assign bus.plot_color = c_q;
  assign bus.cmd_dropped = drop_q;
  assign bus.busy = state_q != IDLE || !empty;
endmodule

// File: tb/tb_square_draw_sequencer.sv
// tb_square_draw_sequencer: renderer model plus scoreboard checking plot stream, dispatch order and timing.
module tb_square_draw_sequencer;
  localparam int DEPTH = 4;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [4:0] s; logic [2:0] c;} cmd_t;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  logic clock = 1'b0, resetn = 1'b0;
  int tests = 0, fails = 0, n_plot = 0, n_drop = 0;
  cmd_t cmd_q[$];
  pix_t pix_q[$];
  logic en_prev = 1'b0;
  logic [4:0] rx, ry;
  logic rf;
  bit p_s[40], e_s[40];
  square_draw_if #(.X_W(8), .Y_W(7), .SIZE_W(5), .COLOR_W(3)) bus ();
  square_draw_sequencer #(.X_W(8), .Y_W(7), .SIZE_W(5), .COLOR_W(3), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .bus(bus.master));
  always #5 clock = ~clock;
  // Renderer: holds at origin while disabled, raster-scans while enabled, then flags finished.
  always @(posedge clock or negedge resetn)
    if (!resetn || !bus.sq_enable) begin
      rx <= '0;
      ry <= '0;
      rf <= 1'b0;
    end else if (!rf) begin
      if (32'(rx) == 32'(bus.sq_size) - 1) begin
        rx <= '0;
        if (32'(ry) == 32'(bus.sq_size) - 1) rf <= 1'b1;
        else ry <= ry + 1'b1;
      end else rx <= rx + 1'b1;
    end
  assign bus.sq_x = bus.sq_origin_x + 8'(rx);
  assign bus.sq_y = bus.sq_origin_y + 7'(ry);
  assign bus.sq_finished = rf;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_push(input cmd_t c);
    cmd_q.push_back(c);
    for (int r = 0; r < int'(c.s); r++)
      for (int q = 0; q < int'(c.s); q++)
        pix_q.push_back('{x: 8'(int'(c.x) + q), y: 7'(int'(c.y) + r), c: c.c});
  endtask
  always @(negedge clock)
    if (!resetn) en_prev <= 1'b0;
    else begin
      if (bus.sq_enable && !en_prev) begin
        if (cmd_q.size() == 0) chk("unexpected_draw", 1, 0);
        else begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("draw_cmd", {bus.sq_origin_x, bus.sq_origin_y, bus.sq_size}, {e.x, e.y, e.s});
        end
      end
      if (bus.cmd_dropped) begin
        n_drop <= n_drop + 1;
        if (cmd_q.size() == 0) chk("unexpected_drop", 1, 0);
        else begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("drop_cmd_size", 64'(e.s), 0);
        end
      end
      if (bus.plot) begin
        n_plot <= n_plot + 1;
        if (pix_q.size() == 0) chk("unexpected_plot", 1, 0);
        else chk("plot_pixel", {bus.plot_x, bus.plot_y, bus.plot_color}, pix_q.pop_front());
      end
      en_prev <= bus.sq_enable;
    end
  task automatic push(input cmd_t c);
    logic r;
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_x = c.x;
    bus.cmd_y = c.y;
    bus.cmd_size = c.s;
    bus.cmd_color = c.c;
    do begin
      r = bus.cmd_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!r && n < 2000);
    bus.cmd_valid = 1'b0;
    if (r) model_push(c);
    else chk("push_timeout", 0, 1);
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("idle_reached", bus.busy, 0);
  endtask
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  initial begin
    int b_plot, b_drop, f, r1, g, r2, lo;
    cmd_t c;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_size = '0;
    bus.cmd_color = '0;
    cycles(3);
    chk("rst_outputs", {bus.cmd_ready, bus.sq_enable, bus.plot, bus.busy, bus.cmd_dropped},
        5'b10000);
    chk("rst_regs", {bus.sq_origin_x, bus.sq_origin_y, bus.sq_size, bus.plot_color}, 0);
    resetn = 1'b1;
    cycles(2);
    // single 2x2 square and its dispatch latency
    b_plot = n_plot;
    push('{x: 8'd10, y: 7'd20, s: 5'd2, c: 3'd5});
    cycles(1);
    chk("t1_enable_load", bus.sq_enable, 0);
    cycles(1);
    chk("t1_enable_draw", bus.sq_enable, 1);
    chk("t1_first_pix", {bus.plot, bus.plot_x, bus.plot_y, bus.plot_color},
        {1'b1, 8'd10, 7'd20, 3'd5});
    wait_idle(100);
    chk("t1_plot_count", 64'(n_plot - b_plot), 4);
    // FIFO fills behind a long draw; extra command is held off
    for (int i = 0; i <= DEPTH; i++) push('{x: 8'(i * 9), y: 7'(i * 5), s: 5'd8, c: 3'(i)});
    chk("t2_full_ready", bus.cmd_ready, 0);
    push('{x: 8'd200, y: 7'd100, s: 5'd8, c: 3'd7});
    wait_idle(3000);
    // zero-size command is dropped
    b_plot = n_plot;
    b_drop = n_drop;
    push('{x: 8'd1, y: 7'd1, s: 5'd0, c: 3'd2});
    push('{x: 8'd3, y: 7'd3, s: 5'd1, c: 3'd4});
    wait_idle(100);
    cycles(2);
    chk("t3_drops", 64'(n_drop - b_drop), 1);
    chk("t3_plots", 64'(n_plot - b_plot), 1);
    // back-to-back squares: run, gap, run
    push('{x: 8'd50, y: 7'd60, s: 5'd3, c: 3'd1});
    push('{x: 8'd70, y: 7'd80, s: 5'd3, c: 3'd6});
    for (int k = 0; k < 40; k++) begin
      p_s[k] = bus.plot;
      e_s[k] = bus.sq_enable;
      cycles(1);
    end
    f = 0;
    while (f < 39 && !p_s[f]) f++;
    r1 = 0;
    while (f + r1 < 40 && p_s[f+r1]) r1++;
    g = 0;
    while (f + r1 + g < 40 && !p_s[f+r1+g]) g++;
    r2 = 0;
    while (f + r1 + g + r2 < 40 && p_s[f+r1+g+r2]) r2++;
    lo = 0;
    for (int k = f; k < f + r1 + g && k < 40; k++) lo += int'(!e_s[k]);
    chk("t4_run1", 64'(r1), 9);
    chk("t4_gap", 64'(g), 3);
    chk("t4_run2", 64'(r2), 9);
    chk("t4_enable_low", 64'(lo), 2);
    wait_idle(100);
    // reset during a draw discards everything
    b_plot = n_plot;
    push('{x: 8'd30, y: 7'd30, s: 5'd4, c: 3'd3});
    push('{x: 8'd40, y: 7'd40, s: 5'd2, c: 3'd2});
    f = 0;
    while (n_plot - b_plot < 3 && f < 100) begin
      @(negedge clock);
      #2;
      f++;
    end
    chk("t5_three_pix", 64'(n_plot - b_plot), 3);
    resetn = 1'b0;
    cmd_q.delete();
    pix_q.delete();
    #1;
    chk("t5_rst_now", {bus.plot, bus.sq_enable, bus.busy}, 0);
    #3;
    resetn = 1'b1;
    b_plot = n_plot;
    cycles(20);
    chk("t5_no_plots", 64'(n_plot - b_plot), 0);
    chk("t5_ready_idle", {bus.cmd_ready, bus.busy}, 2'b10);
    // push coinciding with a pop at DEPTH-1 occupancy
    for (int i = 0; i < DEPTH; i++) push('{x: 8'(100 + i), y: 7'(i), s: 5'd2, c: 3'(i + 1)});
    f = 0;
    while (bus.sq_enable && f < 200) begin
      cycles(1);
      f++;
    end
    push('{x: 8'd5, y: 7'd6, s: 5'd2, c: 3'd7});
    chk("t6_ready_after", bus.cmd_ready, 1);
    push('{x: 8'd7, y: 7'd8, s: 5'd1, c: 3'd1});
    chk("t6_full_after", bus.cmd_ready, 0);
    wait_idle(500);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      cycles($urandom_range(0, 3));
      c.x = 8'($urandom);
      c.y = 7'($urandom);
      c.s = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 5));
      c.c = 3'($urandom);
      push(c);
    end
    wait_idle(5000);
    cycles(3);
    chk("end_cmd_q_empty", 64'(cmd_q.size()), 0);
    chk("end_pix_q_empty", 64'(pix_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
